// File: rtl/priv_1_12_hpm_counters.sv
// Counter bank for the v1.12 privilege block: mcycle, minstret, mhpmcounter3..,
// mhpmevent selectors, mcountinhibit and mcounteren, plus user-mode shadows.
// Reads are combinational; writes commit on the next rising edge of CLK.
module priv_1_12_hpm_counters #(
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [11:0]           csr_addr,
    input  logic [1:0]            curr_priv,
    input  logic                  csr_mod,
    input  logic [31:0]           new_csr_val,
    input  logic                  inst_ret,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic                  hit,
    output logic [31:0]           old_csr_val,
    output logic                  invalid_csr
);

    // Stored selector width and the padded width used to index events by selector value.
    localparam int unsigned EVW = $clog2(NUM_EVENTS + 1);
    localparam int unsigned EVX = 1 << EVW;
    localparam int unsigned HIW = CNT_WIDTH - 32;

    // Counter indices that exist: 0 (cycle), 2 (instret), 3..3+NUM_HPM-1.
    localparam logic [31:0] HPM_MASK  = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
    localparam logic [31:0] IMPL_MASK = HPM_MASK | 32'h0000_0005;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MCNT,
        SEL_UCNT,
        SEL_INH,
        SEL_EVT,
        SEL_EN
    } csr_sel_e;

    logic [CNT_WIDTH-1:0] cnt_q [32];
    logic [CNT_WIDTH-1:0] cnt_d [32];
    logic [EVW-1:0]       evt_q [32];
    logic [EVW-1:0]       evt_d [32];
    logic [31:0]          inh_q, inh_d;
    logic [31:0]          en_q, en_d;

    csr_sel_e    sel;
    logic [4:0]  idx;
    logic        is_hi;
    logic        priv_m;
    logic        priv_u;
    logic        wr;
    logic [31:0] rdata;
    logic [EVX-1:0] ev_ext;

    // Address decode, privilege checks and combinational read data.
    always_comb begin
        idx    = csr_addr[4:0];
        is_hi  = csr_addr[7];
        priv_m = (curr_priv == 2'b11);
        priv_u = (curr_priv == 2'b00);

        sel = SEL_NONE;
        if (csr_addr[11:8] == 4'hB && csr_addr[6:5] == 2'b00 && idx != 5'd1) begin
            sel = SEL_MCNT;
        end else if (csr_addr[11:8] == 4'hC && csr_addr[6:5] == 2'b00 && idx != 5'd1) begin
            sel = SEL_UCNT;
        end else if (csr_addr == 12'h320) begin
            sel = SEL_INH;
        end else if (csr_addr[11:5] == 7'b0011_001 && idx >= 5'd3) begin
            sel = SEL_EVT;
        end else if (csr_addr == 12'h306) begin
            sel = SEL_EN;
        end

        hit = (sel != SEL_NONE);

        invalid_csr = 1'b0;
        if (!priv_m && (sel == SEL_MCNT || sel == SEL_INH || sel == SEL_EVT || sel == SEL_EN)) begin
            invalid_csr = 1'b1;
        end
        if (sel == SEL_UCNT && (csr_mod || (priv_u && !en_q[idx]))) begin
            invalid_csr = 1'b1;
        end

        wr = hit && csr_mod && !invalid_csr;

        rdata = '0;
        case (sel)
            SEL_MCNT, SEL_UCNT: rdata = is_hi ? 32'(cnt_q[idx][CNT_WIDTH-1:32]) : cnt_q[idx][31:0];
            SEL_INH:            rdata = inh_q;
            SEL_EVT:            rdata = 32'(evt_q[idx]);
            SEL_EN:             rdata = en_q;
            default:            rdata = '0;
        endcase

        old_csr_val = invalid_csr ? '0 : rdata;
    end

    // Next state: per-counter increment, then CSR write overriding the written half.
    always_comb begin : next_state
        logic                 fire;
        logic [CNT_WIDTH-1:0] inc;

        // Selector value k picks event_in[k-1]; selector 0 and padding slots never fire.
        ev_ext = '0;
        ev_ext[NUM_EVENTS:0] = {event_in, 1'b0};

        inh_d = inh_q;
        en_d  = en_q;
        if (wr && sel == SEL_INH) inh_d = new_csr_val & IMPL_MASK;
        if (wr && sel == SEL_EN)  en_d  = new_csr_val & IMPL_MASK;

        for (int unsigned i = 0; i < 32; i++) begin
            cnt_d[i] = '0;
            evt_d[i] = '0;
            fire     = 1'b0;
            inc      = '0;
            if (IMPL_MASK[i]) begin
                if (i == 0)      fire = 1'b1;
                else if (i == 2) fire = inst_ret;
                else             fire = ev_ext[evt_q[i]];
                fire = fire && !inh_q[i];

                inc      = cnt_q[i] + CNT_WIDTH'(fire);
                cnt_d[i] = inc;
                // A hi write keeps the freshly incremented lo half; its carry is dropped.
                if (wr && sel == SEL_MCNT && idx == 5'(i)) begin
                    if (is_hi) cnt_d[i] = {new_csr_val[HIW-1:0], inc[31:0]};
                    else       cnt_d[i] = {cnt_q[i][CNT_WIDTH-1:32], new_csr_val};
                end

                evt_d[i] = evt_q[i];
                if (i >= 3 && wr && sel == SEL_EVT && idx == 5'(i)) begin
                    evt_d[i] = (new_csr_val > 32'(NUM_EVENTS)) ? '0 : new_csr_val[EVW-1:0];
                end
            end
        end
    end

    // State registers with synchronous reset taking priority over writes and counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
                evt_q[i] <= '0;
            end
            inh_q <= '0;
            en_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            inh_q <= inh_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: tb/tb_priv_1_12_hpm_counters.sv
// Self-checking bench: two configurations (64-bit/4 HPM/8 events and 40-bit/2 HPM/3 events)
// share all inputs and are compared every cycle against a behavioural model.
module tb_priv_1_12_hpm_counters;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic [1:0]  priv;
    logic        mod;
    logic [31:0] wdata;
    logic        ir;
    logic [7:0]  ev;

    logic        hit_a, inv_a, hit_b, inv_b;
    logic [31:0] val_a, val_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priv_1_12_hpm_counters #(.NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVENTS(8)) dut_a (
        .CLK(clk), .RST(rst), .csr_addr(addr), .curr_priv(priv), .csr_mod(mod),
        .new_csr_val(wdata), .inst_ret(ir), .event_in(ev),
        .hit(hit_a), .old_csr_val(val_a), .invalid_csr(inv_a)
    );

    priv_1_12_hpm_counters #(.NUM_HPM(2), .CNT_WIDTH(40), .NUM_EVENTS(3)) dut_b (
        .CLK(clk), .RST(rst), .csr_addr(addr), .curr_priv(priv), .csr_mod(mod),
        .new_csr_val(wdata), .inst_ret(ir), .event_in(ev[2:0]),
        .hit(hit_b), .old_csr_val(val_b), .invalid_csr(inv_b)
    );

    // ---------------- reference model ----------------
    int unsigned     c_hpm [2] = '{4, 2};
    int unsigned     c_cw  [2] = '{64, 40};
    int unsigned     c_ne  [2] = '{8, 3};
    longint unsigned m_cnt [2][32];
    int unsigned     m_evt [2][32];
    logic [31:0]     m_inh [2];
    logic [31:0]     m_en  [2];

    localparam logic [11:0] ATAB [26] = '{
        12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'hB05,
        12'hB86, 12'hB1F, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC84, 12'h320,
        12'h323, 12'h324, 12'h325, 12'h33F, 12'h306, 12'hB01, 12'h7C0, 12'hC01
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit impl(input int c, input int unsigned n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + c_hpm[c]);
    endfunction

    function automatic logic [31:0] impl_bits(input int c);
        logic [31:0] m = '0;
        for (int unsigned i = 0; i < 32; i++) if (impl(c, i)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic longint unsigned wmask(input int c);
        return (c_cw[c] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << c_cw[c]) - 64'd1);
    endfunction

    // 0 none, 1 machine counter, 2 user shadow, 3 mcountinhibit, 4 mhpmevent, 5 mcounteren
    function automatic int cls(input logic [11:0] a);
        int unsigned n = a[4:0];
        if (((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) && n != 1) return 1;
        if (((a >= 12'hC00 && a <= 12'hC1F) || (a >= 12'hC80 && a <= 12'hC9F)) && n != 1) return 2;
        if (a == 12'h320) return 3;
        if (a >= 12'h323 && a <= 12'h33F) return 4;
        if (a == 12'h306) return 5;
        return 0;
    endfunction

    function automatic void model_access(input int c, output bit h, output bit inv, output logic [31:0] v);
        int          k  = cls(addr);
        int unsigned n  = addr[4:0];
        bit          hi = addr[7];
        h   = (k != 0);
        inv = h && ((priv != 2'b11 && (k == 1 || k >= 3)) ||
                    (k == 2 && (mod || (priv == 2'b00 && !m_en[c][n]))));
        v = 0;
        case (k)
            1, 2: v = hi ? 32'(m_cnt[c][n] >> 32) : 32'(m_cnt[c][n]);
            3:    v = m_inh[c];
            4:    v = m_evt[c][n];
            5:    v = m_en[c];
            default: v = 0;
        endcase
        if (inv) v = 0;
    endfunction

    function automatic void model_edge(input int c);
        bit h, inv, wr, fire, hi;
        logic [31:0] v;
        int k;
        int unsigned n;
        longint unsigned nxt, hmask;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_cnt[c][i] = 0; m_evt[c][i] = 0; end
            m_inh[c] = 0;
            m_en[c]  = 0;
            return;
        end
        model_access(c, h, inv, v);
        k     = cls(addr);
        n     = addr[4:0];
        hi    = addr[7];
        wr    = h && mod && !inv;
        hmask = (64'd1 << (c_cw[c] - 32)) - 64'd1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!impl(c, i)) continue;
            if (i == 0)      fire = 1;
            else if (i == 2) fire = ir;
            else             fire = (m_evt[c][i] >= 1 && m_evt[c][i] <= c_ne[c] && ev[m_evt[c][i] - 1]);
            if (m_inh[c][i]) fire = 0;
            nxt = (m_cnt[c][i] + 64'(fire)) & wmask(c);
            if (wr && k == 1 && n == i) begin
                if (hi) nxt = ((64'(wdata) & hmask) << 32) | (nxt & 64'hFFFF_FFFF);
                else    nxt = (m_cnt[c][i] & 64'hFFFF_FFFF_0000_0000) | 64'(wdata);
            end
            m_cnt[c][i] = nxt;
        end
        if (wr && k == 3) m_inh[c] = wdata & impl_bits(c);
        if (wr && k == 5) m_en[c]  = wdata & impl_bits(c);
        if (wr && k == 4 && impl(c, n)) m_evt[c][n] = (wdata > c_ne[c]) ? 0 : wdata;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit h, inv;
        logic [31:0] v;
        @(negedge clk);
        model_access(0, h, inv, v);
        check($sformatf("A hit @%h", addr), {31'b0, hit_a}, {31'b0, h});
        check($sformatf("A inv @%h", addr), {31'b0, inv_a}, {31'b0, inv});
        check($sformatf("A val @%h", addr), val_a, v);
        model_access(1, h, inv, v);
        check($sformatf("B hit @%h", addr), {31'b0, hit_b}, {31'b0, h});
        check($sformatf("B inv @%h", addr), {31'b0, inv_b}, {31'b0, inv});
        check($sformatf("B val @%h", addr), val_b, v);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic put(input logic [11:0] a, input logic [1:0] p, input logic m, input logic [31:0] d);
        addr  = a;
        priv  = p;
        mod   = m;
        wdata = d;
        #1;
    endtask

    task automatic wr_m(input logic [11:0] a, input logic [31:0] d);
        put(a, 2'b11, 1'b1, d);
        cycle();
    endtask

    initial begin
        rst = 1'b1; addr = '0; priv = 2'b11; mod = 1'b0; wdata = '0; ir = 1'b0; ev = '0;
        for (int c = 0; c < 2; c++) model_edge(c);
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // Counting starts on the first edge after reset drops.
        for (int i = 0; i < 10; i++) cycle();
        put(12'hB00, 2'b11, 1'b0, '0);
        check("t1 lo A", val_a, 32'd10);
        check("t1 lo B", val_b, 32'd10);
        cycle();
        put(12'hB80, 2'b11, 1'b0, '0);
        check("t1 hi A", val_a, 32'd0);
        cycle();

        // Carry from lo into hi, then full-width wrap.
        wr_m(12'hB80, 32'h0);
        wr_m(12'hB00, 32'hFFFF_FFFF);
        put(12'h000, 2'b11, 1'b0, '0);
        cycle();
        put(12'hB00, 2'b11, 1'b0, '0);
        check("t2 lo A", val_a, 32'd0);
        cycle();
        put(12'hB80, 2'b11, 1'b0, '0);
        check("t2 hi A", val_a, 32'd1);
        check("t2 hi B", val_b, 32'd1);
        cycle();
        wr_m(12'hB80, 32'h0000_00FF);
        wr_m(12'hB00, 32'hFFFF_FFFF);
        put(12'h000, 2'b11, 1'b0, '0);
        cycle();
        put(12'hB00, 2'b11, 1'b0, '0);
        check("t2 wrap lo B", val_b, 32'd0);
        check("t2 wrap lo A", val_a, 32'd0);
        cycle();
        put(12'hB80, 2'b11, 1'b0, '0);
        check("t2 wrap hi B", val_b, 32'd0);
        check("t2 nowrap hi A", val_a, 32'h100);
        cycle();

        // Event selection.
        wr_m(12'h323, 32'd2);
        wr_m(12'hB03, 32'd0);
        for (int i = 0; i < 5; i++) begin
            ev = {6'b0, 1'b1, i[0]};
            put(12'h000, 2'b11, 1'b0, '0);
            cycle();
        end
        ev = '0;
        put(12'hB03, 2'b11, 1'b0, '0);
        check("t3 cnt A", val_a, 32'd5);
        check("t3 cnt B", val_b, 32'd5);
        cycle();
        wr_m(12'h323, 32'd9);
        put(12'h323, 2'b11, 1'b0, '0);
        check("t3 sel A", val_a, 32'd0);
        check("t3 sel B", val_b, 32'd0);
        cycle();
        ev = 8'hFF;
        for (int i = 0; i < 3; i++) cycle();
        ev = '0;
        put(12'hB03, 2'b11, 1'b0, '0);
        check("t3 frozen A", val_a, 32'd5);
        cycle();

        // Inhibit.
        wr_m(12'h320, 32'h5);
        wr_m(12'hB00, 32'h0);
        wr_m(12'hB02, 32'h0);
        ir = 1'b1;
        put(12'h000, 2'b11, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle();
        ir = 1'b0;
        put(12'hB00, 2'b11, 1'b0, '0);
        check("t4 cyc frozen", val_a, 32'd0);
        cycle();
        put(12'hB02, 2'b11, 1'b0, '0);
        check("t4 ret frozen", val_a, 32'd0);
        cycle();
        wr_m(12'h320, 32'h7);
        put(12'h320, 2'b11, 1'b0, '0);
        check("t4 inh A", val_a, 32'h5);
        check("t4 inh B", val_b, 32'h5);
        cycle();
        wr_m(12'h320, 32'h0);
        ir = 1'b1;
        put(12'h000, 2'b11, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle();
        ir = 1'b0;
        put(12'hB00, 2'b11, 1'b0, '0);
        check("t4 cyc resume", val_a, 32'd3);
        cycle();
        put(12'hB02, 2'b11, 1'b0, '0);
        check("t4 ret resume", val_a, 32'd3);
        cycle();

        // User shadows and privilege checks.
        wr_m(12'h306, 32'h0);
        put(12'hC00, 2'b00, 1'b0, '0);
        check("t5 gated inv", {31'b0, inv_a}, 32'd1);
        check("t5 gated val", val_a, 32'd0);
        cycle();
        wr_m(12'h306, 32'h1);
        put(12'hC00, 2'b00, 1'b0, '0);
        check("t5 open inv", {31'b0, inv_a}, 32'd0);
        check("t5 open val", val_a, 32'd8);
        cycle();
        put(12'hC00, 2'b11, 1'b1, 32'h1234);
        check("t5 shadow wr", {31'b0, inv_a}, 32'd1);
        cycle();
        put(12'hB00, 2'b00, 1'b0, '0);
        check("t5 U mcycle", {31'b0, inv_b}, 32'd1);
        cycle();

        // Write beats increment; unimplemented and unmapped addresses.
        ir = 1'b1;
        wr_m(12'hB02, 32'd7);
        ir = 1'b0;
        put(12'hB02, 2'b11, 1'b0, '0);
        check("t6 wr A", val_a, 32'd7);
        check("t6 wr B", val_b, 32'd7);
        cycle();
        put(12'hB1F, 2'b11, 1'b0, '0);
        check("t6 unimpl hit", {31'b0, hit_a}, 32'd1);
        check("t6 unimpl val", val_a, 32'd0);
        cycle();
        put(12'h7C0, 2'b11, 1'b0, '0);
        check("t6 unmapped", {31'b0, hit_a}, 32'd0);
        cycle();

        // Reset wins over a concurrent write.
        rst = 1'b1;
        wr_m(12'hB00, 32'd55);
        rst = 1'b0;
        put(12'hB00, 2'b11, 1'b0, '0);
        check("rst over wr", val_a, 32'd0);
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            logic [1:0]  p;
            rst = ($urandom % 97) == 0;
            ir  = $urandom % 2;
            ev  = 8'($urandom);
            case ($urandom % 4)
                0:       d = $urandom;
                1:       d = $urandom_range(0, 12);
                2:       d = 32'hFFFF_FFFF;
                default: d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            case ($urandom % 4)
                0, 1:    p = 2'b11;
                2:       p = 2'b00;
                default: p = 2'b01;
            endcase
            put(ATAB[$urandom % 26], p, ($urandom % 3) == 0, d);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
